// File: rtl/vga_fifo_scanout.sv
// ---------------------------------------------------------------------------
// vga_fifo_scanout
//
// Scans a 1-bit video line FIFO out to a VGA PMOD. It generates the raster
// timing and strobes the FIFO so that each strobe reads one image pixel and
// writes one new source bit. Each image pixel is stretched horizontally
// over H_SCALE screen columns inside a window starting at X_OFFSET.
//
// Before every frame, on the last line of vertical blanking, PRIME_LEN
// strobes pre-fill the FIFO. During active lines the FIFO holds a constant
// occupancy because every strobe both reads and writes.
//
// Legal parameters need X_OFFSET >= 2, X_OFFSET + IMG_W*H_SCALE <= H_ACTIVE,
// and H_SCALE a power of two.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous, active-high reset
//   fifo_dout    FIFO read data; updates on the edge that samples fifo_en
//   src_bit      next pixel bit from the upstream frame source
//   fifo_en      FIFO enable strobe (registered)
//   fifo_din     FIFO write data, a combinational copy of src_bit
//   src_ack      copy of fifo_en; upstream advances when this is high
//   line_start   one-cycle pulse while h_cnt == 0
//   frame_start  one-cycle pulse while h_cnt == 0 and v_cnt == 0
//   hsync        active-low horizontal sync (registered)
//   vsync        active-low vertical sync (registered)
//   de           display enable (registered)
//   rgb          {R[1:0],G[1:0],B[1:0]} (registered, aligned with de)
// ---------------------------------------------------------------------------
module vga_fifo_scanout #(
   parameter int         H_ACTIVE  = 640,
   parameter int         H_FP      = 16,
   parameter int         H_SYNC    = 96,
   parameter int         H_BP      = 48,
   parameter int         V_ACTIVE  = 480,
   parameter int         V_FP      = 10,
   parameter int         V_SYNC    = 2,
   parameter int         V_BP      = 33,
   parameter int         IMG_W     = 256,
   parameter int         H_SCALE   = 2,
   parameter int         X_OFFSET  = 64,
   parameter int         PRIME_LEN = 255,
   parameter logic [5:0] FG_COLOR  = 6'b111111,
   parameter logic [5:0] BG_COLOR  = 6'b000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_dout,
   input  logic       src_bit,
   output logic       fifo_en,
   output logic       fifo_din,
   output logic       src_ack,
   output logic       line_start,
   output logic       frame_start,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic [5:0] rgb
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);

   localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT_END   = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] HS_START    = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] HS_END      = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [H_W-1:0] WIN_START   = H_W'(X_OFFSET);
   localparam logic [H_W-1:0] WIN_END     = H_W'(X_OFFSET + IMG_W * H_SCALE);
   localparam logic [H_W-1:0] FETCH_START = H_W'(X_OFFSET - 2);
   localparam logic [H_W-1:0] FETCH_END   = H_W'(X_OFFSET - 2 + IMG_W * H_SCALE);
   localparam logic [H_W-1:0] PRIME_END   = H_W'(PRIME_LEN);
   localparam logic [H_W-1:0] SCALE_MASK  = H_W'(H_SCALE - 1);
   localparam logic [H_W-1:0] H_ONE       = H_W'(1);

   localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT_END   = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] VS_START    = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] VS_END      = V_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [V_W-1:0] V_ONE       = V_W'(1);

   logic [H_W-1:0] h_cnt;
   logic [H_W-1:0] h_next;
   logic [V_W-1:0] v_cnt;
   logic [V_W-1:0] v_next;
   logic           h_wrap;
   logic           prime_hit;
   logic           fetch_hit;
   logic           en_d;
   logic           pixel;
   logic           de_raw;
   logic           in_win;
   logic           hs_raw;
   logic           vs_raw;
   logic [5:0]     rgb_raw;

   // The FIFO write side is fed straight from the source, and the source is
   // told to advance exactly when the FIFO takes a bit.
   assign fifo_din = src_bit;
   assign src_ack  = fifo_en;

   // Next raster position. The strobes and start pulses are decoded from
   // this value so that, once registered, they line up with the cycle in
   // which h_cnt/v_cnt actually hold the decoded position.
   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      h_next = h_wrap ? '0 : h_cnt + H_ONE;
      v_next = v_cnt;
      if (h_wrap) begin
         v_next = (v_cnt == V_LAST) ? '0 : v_cnt + V_ONE;
      end
   end

   // Strobe windows. Prime: a burst at the start of the final blanking line.
   // Fetch: one strobe every H_SCALE columns, two columns ahead of the image
   // window, because the FIFO output and then the pixel register each add a
   // cycle before a pixel reaches the output stage.
   always_comb begin
      prime_hit = (v_next == V_LAST) && (h_next < PRIME_END);
      fetch_hit = (v_next < V_ACT_END)
                  && (h_next >= FETCH_START) && (h_next < FETCH_END)
                  && (((h_next - FETCH_START) & SCALE_MASK) == '0);
   end

   // Raster counters: h_cnt runs across the line, v_cnt steps on each wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_next;
         v_cnt <= v_next;
      end
   end

   // Registered strobe and start pulses. en_d marks the cycle in which
   // fifo_dout carries the pixel just read, so the pixel register can take it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_en     <= 1'b0;
         en_d        <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         fifo_en     <= prime_hit | fetch_hit;
         en_d        <= fifo_en;
         line_start  <= (h_next == '0);
         frame_start <= (h_next == '0) && (v_next == '0);
      end
   end

   // Pixel register: loads one cycle after the FIFO has updated and then
   // holds for the H_SCALE columns that the pixel occupies on screen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel <= 1'b0;
      end else if (en_d) begin
         pixel <= fifo_dout;
      end
   end

   // Raw display decode for the current column. The pixel register already
   // holds the image pixel that belongs to this column.
   always_comb begin
      de_raw  = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      in_win  = (h_cnt >= WIN_START) && (h_cnt < WIN_END);
      hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
      rgb_raw = 6'b000000;
      if (de_raw) begin
         rgb_raw = (in_win && pixel) ? FG_COLOR : BG_COLOR;
      end
   end

   // Output stage: syncs, de and rgb all pass through one register so that
   // they stay mutually aligned at the connector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         de    <= 1'b0;
         rgb   <= 6'b000000;
      end else begin
         hsync <= hs_raw;
         vsync <= vs_raw;
         de    <= de_raw;
         rgb   <= rgb_raw;
      end
   end

endmodule

// File: tb/tb_vga_fifo_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_fifo_scanout
//
// Bench for vga_fifo_scanout, run on a shrunken raster so that whole frames
// fit in a short simulation:
//   horizontal 48 active + 4 FP + 8 sync + 4 BP = 64 clocks per line
//   vertical    6 active + 2 FP + 2 sync + 3 BP = 13 lines per frame
//   image 16 pixels x2 in window [8,40), prime 15, frame = 832 clocks
// Expected raw sync windows: hsync low for h in [52,60), vsync low for
// v in [8,10); outputs show these one clock later (registered stage).
// Fetch strobes fall at h = 6,8,...,36 on lines 0..5; prime at h = 0..14
// on line 12. FG/BG are set to distinct non-zero codes so that background
// inside de can be told apart from blanking.
//
// The upstream source is an alternating bit stream starting at 1, and the
// FIFO is modelled as a 16-stage shift register advanced on every fifo_en.
// ---------------------------------------------------------------------------
module tb_vga_fifo_scanout;

   localparam int         H_TOTAL    = 64;
   localparam int         V_TOTAL    = 13;
   localparam int         H_ACTIVE   = 48;
   localparam int         FRAME      = 832;
   localparam int         FIFO_DEPTH = 16;
   localparam logic [5:0] FG         = 6'b110100;
   localparam logic [5:0] BG         = 6'b000110;

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_dout;
   logic       src_bit;
   logic       fifo_en;
   logic       fifo_din;
   logic       src_ack;
   logic       line_start;
   logic       frame_start;
   logic       hsync;
   logic       vsync;
   logic       de;
   logic [5:0] rgb;

   int checks = 0;
   int errors = 0;

   // Reference raster position and expected registered outputs.
   int         mh;
   int         mv;
   int         cyc;
   logic       e_hsync;
   logic       e_vsync;
   logic       e_de;
   logic       e_fen;
   logic       e_ls;
   logic       e_fs;
   logic [5:0] e_rgb;

   // FIFO model and per-column image pixel expected on the current line.
   logic [FIFO_DEPTH-1:0] fifo_sr;
   logic                  colpix [H_ACTIVE];

   // Directed measurements.
   logic       count_en;
   int         line_fen [V_TOTAL];
   logic [5:0] col_rgb [H_ACTIVE];
   int         first_fen_h;
   int         last_fs;
   int         fs_period;
   int         last_hs_fall;
   int         hs_period;
   logic       prev_hsync;
   int         low_at;
   int         total_fen;
   logic [5:0] exp_col;

   vga_fifo_scanout #(
      .H_ACTIVE  (48),
      .H_FP      (4),
      .H_SYNC    (8),
      .H_BP      (4),
      .V_ACTIVE  (6),
      .V_FP      (2),
      .V_SYNC    (2),
      .V_BP      (3),
      .IMG_W     (16),
      .H_SCALE   (2),
      .X_OFFSET  (8),
      .PRIME_LEN (15),
      .FG_COLOR  (FG),
      .BG_COLOR  (BG)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_dout   (fifo_dout),
      .src_bit     (src_bit),
      .fifo_en     (fifo_en),
      .fifo_din    (fifo_din),
      .src_ack     (src_ack),
      .line_start  (line_start),
      .frame_start (frame_start),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .rgb         (rgb)
   );

   // Free-running pixel clock, posedges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any miss.
   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outputs must sit at their reset values.
   task automatic checkResetState(input string where);
      checkValue({where, " hsync"}, hsync, 1'b1);
      checkValue({where, " vsync"}, vsync, 1'b1);
      checkValue({where, " de"}, de, 1'b0);
      checkValue({where, " rgb"}, rgb, 6'b000000);
      checkValue({where, " fifo_en"}, fifo_en, 1'b0);
      checkValue({where, " line_start"}, line_start, 1'b0);
      checkValue({where, " frame_start"}, frame_start, 1'b0);
   endtask

   // Compare every output against the reference for the current cycle.
   task automatic checkOutput();
      string pos;
      pos = $sformatf("h%0d v%0d", mh, mv);
      checkValue({"hsync ", pos}, hsync, e_hsync);
      checkValue({"vsync ", pos}, vsync, e_vsync);
      checkValue({"de ", pos}, de, e_de);
      checkValue({"rgb ", pos}, rgb, e_rgb);
      checkValue({"fifo_en ", pos}, fifo_en, e_fen);
      checkValue({"line_start ", pos}, line_start, e_ls);
      checkValue({"frame_start ", pos}, frame_start, e_fs);
      checkValue({"src_ack ", pos}, src_ack, fifo_en);
      checkValue({"fifo_din ", pos}, fifo_din, src_bit);
   endtask

   // Reference state right after reset release.
   task automatic resetModel();
      mh           = 0;
      mv           = 0;
      cyc          = 0;
      e_hsync      = 1'b1;
      e_vsync      = 1'b1;
      e_de         = 1'b0;
      e_rgb        = 6'b000000;
      e_fen        = 1'b0;
      e_ls         = 1'b0;
      e_fs         = 1'b0;
      last_fs      = -1;
      last_hs_fall = -1;
      prev_hsync   = 1'b1;
   endtask

   // Advance the reference across one clock edge. Expected registers take
   // the values decoded from the position before the edge; strobe and start
   // pulses are decoded for the position after it.
   task automatic modelEdge(input logic fen);
      int nh;
      int nv;
      nh = (mh == H_TOTAL - 1) ? 0 : mh + 1;
      nv = mv;
      if (mh == H_TOTAL - 1) nv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
      e_de = (mh < 48) && (mv < 6);
      if (!e_de) e_rgb = 6'b000000;
      else if (mh >= 8 && mh < 40) e_rgb = colpix[mh] ? FG : BG;
      else e_rgb = BG;
      e_hsync = !(mh >= 52 && mh < 60);
      e_vsync = !(mv >= 8 && mv < 10);
      e_fen = (nv == 12 && nh < 15) || (nv < 6 && nh >= 6 && nh < 38 && (nh % 2) == 0);
      e_ls = (nh == 0);
      e_fs = (nh == 0) && (nv == 0);
      // FIFO and source react to the strobe the DUT actually issued; the
      // pixel read by a strobe at column c covers screen columns c+2, c+3.
      if (fen) begin
         fifo_dout = fifo_sr[FIFO_DEPTH-1];
         fifo_sr   = {fifo_sr[FIFO_DEPTH-2:0], src_bit};
         src_bit   = ~src_bit;
         if (mv < 6 && mh + 3 < H_ACTIVE) begin
            colpix[mh+2] = fifo_dout;
            colpix[mh+3] = fifo_dout;
         end
      end
      mh = nh;
      mv = nv;
      cyc++;
   endtask

   // Run n clocks. Entered and left at a falling edge: check, measure,
   // then step across the next rising edge.
   task automatic applyStimulus(input int n);
      logic fen;
      repeat (n) begin
         checkOutput();
         if (prev_hsync === 1'b1 && hsync === 1'b0) begin
            if (last_hs_fall >= 0) hs_period = cyc - last_hs_fall;
            last_hs_fall = cyc;
         end
         prev_hsync = hsync;
         if (frame_start === 1'b1) begin
            if (last_fs >= 0) fs_period = cyc - last_fs;
            last_fs = cyc;
         end
         if (count_en) begin
            if (fifo_en === 1'b1) begin
               line_fen[mv]++;
               if (mv == 0 && first_fen_h < 0) first_fen_h = mh;
            end
            if (mv == 0 && mh >= 1 && mh <= H_ACTIVE) col_rgb[mh-1] = rgb;
         end
         fen = fifo_en;
         @(posedge clk);
         #1;
         modelEdge(fen);
         @(negedge clk);
      end
   endtask

   initial begin
      rst         = 1'b1;
      fifo_dout   = 1'b0;
      src_bit     = 1'b1;
      fifo_sr     = '0;
      count_en    = 1'b0;
      first_fen_h = -1;
      fs_period   = -1;
      hs_period   = -1;
      low_at      = -1;
      total_fen   = 0;
      for (int i = 0; i < H_ACTIVE; i++) begin
         colpix[i]  = 1'b0;
         col_rgb[i] = 6'b000000;
      end
      for (int i = 0; i < V_TOTAL; i++) line_fen[i] = 0;

      // Held in reset across several edges.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetState("power-on reset");
      resetModel();
      rst = 1'b0;

      // Frame 1 from reset, then frame 2 with per-line measurement.
      applyStimulus(FRAME);
      count_en = 1'b1;
      applyStimulus(FRAME);
      count_en = 1'b0;
      applyStimulus(1);

      // Strobes per line: 16 on lines 0..5, 15 prime on line 12, none else.
      for (int l = 0; l < V_TOTAL; l++) begin
         checkValue($sformatf("fifo_en count line %0d", l), line_fen[l],
                    (l < 6) ? 16 : ((l == 12) ? 15 : 0));
         total_fen += line_fen[l];
      end
      checkValue("fifo_en total per frame", total_fen, 111);
      checkValue("frame_start period", fs_period, 832);
      checkValue("hsync period", hs_period, 64);
      checkValue("first fifo_en column", first_fen_h, 6);

      // Frame 2 line 0: 111 strobes came before it and the FIFO is 16 deep,
      // so image pixel k carries source bit 95+k, which is 1 for odd k.
      // Columns 8,9 are BG, 10,11 FG, and so on; margins are BG.
      for (int x = 0; x < H_ACTIVE; x++) begin
         if (x < 8 || x >= 40) exp_col = BG;
         else exp_col = ((((x - 8) / 2) % 2) == 1) ? FG : BG;
         checkValue($sformatf("line0 column %0d rgb", x), col_rgb[x], exp_col);
      end

      // Move to h=30 on line 3 of frame 3 and reset between edges.
      applyStimulus(3 * H_TOTAL + 29);
      checkValue("position before mid reset", mh * 100 + mv, 3003);
      rst = 1'b1;
      #1;
      checkResetState("async reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetState("held reset");
      resetModel();
      rst = 1'b0;

      // hsync must first drop after exactly 53 edges: raw low at h=52,
      // visible one register later.
      for (int k = 0; k < 2 * H_TOTAL; k++) begin
         if (hsync === 1'b0) begin
            low_at = k;
            break;
         end
         applyStimulus(1);
      end
      checkValue("hsync low after reset release", low_at, 53);

      applyStimulus(FRAME);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
